pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised chain of pipeline registers carrying a PC and an opaque payload from fetch to write-back, replacing the hand-instantiated per-stage registers in the ARM top level. Each stage has a valid bit, per-stage stall (freeze) with automatic bubble insertion, and per-stage flush for branch recovery. Optionally it counts retired instructions at the chain output.

## Interface
- `WIDTH`, default 32: payload width per stage.
- `PC_W`, default 32: PC width.
- `STAGES`, default 4: number of register stages, at least 2. Stage 0 is the IF/ID register and stage `STAGES-1` is the last.
- `CNT_W`, default 32: retire counter width.
- `CLK` input 1: the single clock; all state updates on its rising edge.
- `RST` input 1: synchronous, active-high reset.
- `in_valid` input 1: an instruction is presented to stage 0.
- `in_pc` input `PC_W`: PC of the presented instruction.
- `in_data` input `WIDTH`: payload of the presented instruction.
- `stall` input `STAGES`: `stall[i]` freezes stage i.
- `flush` input `STAGES`: `flush[i]` kills stage i.
- `in_ready` output 1: stage 0 accepts input this cycle.
- `out_valid` output 1: valid bit of the last stage.
- `out_pc` output `PC_W`: PC of the last stage.
- `out_data` output `WIDTH`: payload of the last stage.
- `stage_valid` output `STAGES`: valid bit of each stage.
- `stage_pc` output `STAGES*PC_W`: PC of each stage; stage i occupies bits `[i*PC_W +: PC_W]`.
- `retire_cnt` output `CNT_W`: instructions retired. Present only with the macro in Configuration.

## Operation
- Hold term per stage: `hold[i] = OR(stall[j])` for all j ≥ i. A stall freezes its own stage and every upstream stage.
- `in_ready = ~hold[0]`. The upstream producer must keep `in_*` stable while `in_ready` is 0.
- Stage i update at each edge, first matching rule wins:
  1. `RST`: valid ← 0, pc ← 0, data ← 0.
  2. `flush[i]`: valid ← 0. pc and data are don't-care but must hold their values so there is no toggling.
  3. `hold[i]`: stage i keeps its current value.
  4. i = 0: stage 0 loads `in_valid`, `in_pc`, `in_data`.
  5. i > 0 and `hold[i-1]`: a bubble is inserted. valid ← 0, pc and data hold.
  6. Otherwise stage i loads stage i-1 (valid, pc, data).
- Flush overrides stall on the same stage. A stalled and flushed stage becomes a bubble while upstream stages stay frozen.
- Flushing stage i does not affect stage i+1, which advances normally. To kill stages 0..k, assert `flush[k:0]`.
- A stage with valid=0 is a bubble. Bubbles move through the chain exactly like instructions but are never counted.
- `out_*` are driven directly from the last-stage registers. There is no combinational path from `in_*` to `out_*`.

## Timing
- Reset values: all `stage_valid`, `stage_pc`, `out_valid`, `out_pc`, `out_data` and `retire_cnt` are 0. `in_ready` is 1 after reset when no stall is asserted.
- Latency: with no stalls or flushes, an instruction accepted at edge n appears on `out_*` after edge n+STAGES-1, i.e. STAGES edges including the capture edge. Throughput is 1 per cycle.
- `in_ready` is combinational from `stall` only.
- Retire event: `valid[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1]`.
  - Each retire event increments `retire_cnt` by 1 at the edge.
  - The counter wraps from 2^CNT_W−1 to 0.
- `RST` asserted mid-stream clears everything at the next edge, regardless of stall or flush. No instruction retires on that edge.

## Configuration
- `PIPE_RETIRE_CNT_EN`:
  - Defined: the `retire_cnt` port and its counter exist, behaving as described in Timing.
  - Undefined: the port and counter are removed. All other behaviour is identical.

## Test plan
- Streaming, STAGES=4: PCs 0x0, 0x4, 0x8, … presented with `in_valid`=1 every cycle after reset. `out_pc`=0x0 appears after the 4th edge, then +4 each cycle. `retire_cnt`=N after N retirements.
- Stall of stage 1, STAGES=4: with stages 0–3 holding 0x10, 0x0C, 0x08, 0x04, assert `stall=4'b0010` for 2 cycles.
  - `in_ready`=0.
  - Stages 0–1 keep 0x10 and 0x0C.
  - Stage 2 becomes a bubble, and the bubble reaches stage 3 one edge later.
  - After release, 0x0C resumes with no loss or duplication.
- Flush: assert `flush=4'b0011` for one cycle with the pipe full. Stages 0–1 become valid=0, stages 2–3 advance normally, and exactly 2 instructions are missing from the retire count.
- Flush and stall on the same stage: `stall[2]`=1 and `flush[2]`=1. Stage 2 becomes valid=0, stages 0–1 stay frozen, stage 3 receives a bubble, and `retire_cnt` increments only if stage 3 was valid.
- Reset mid-stream: pipe full and `stall[3]`=1, then assert `RST` for 1 cycle. All valid bits, PCs and `retire_cnt` read 0 after the edge, and `in_ready`=1 once stalls are cleared.
- Counter wrap and macro: with `CNT_W`=4, retire 17 instructions and check `retire_cnt`=1. Build without `PIPE_RETIRE_CNT_EN`: the port is absent and the streaming test still passes.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised chain of valid/PC/payload pipeline registers
// with per-stage stall (upstream freeze plus bubble insertion) and per-stage
// flush. Optional retire counter at the chain output, built only when the
// PIPE_RETIRE_CNT_EN macro is defined.
module pipe_stage_chain #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [WIDTH-1:0]         out_data,
  output logic [STAGES-1:0]        stage_valid,
`ifdef PIPE_RETIRE_CNT_EN
  output logic [CNT_W-1:0]         retire_cnt,
`endif
  output logic [STAGES*PC_W-1:0]   stage_pc
);

  localparam int unsigned LAST = STAGES - 1;

  // Reject configurations the chain cannot represent
  if (STAGES < 2 || CNT_W < 1) begin : g_param_check
    $error("pipe_stage_chain: STAGES must be >= 2 and CNT_W >= 1");
  end

  logic [STAGES-1:0]             hold_c;
  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][PC_W-1:0]   pc_q,    pc_d;
  logic [STAGES-1:0][WIDTH-1:0]  data_q,  data_d;

  // A stall freezes its own stage and everything upstream of it
  always_comb begin
    hold_c       = '0;
    hold_c[LAST] = stall[LAST];
    for (int i = int'(LAST) - 1; i >= 0; i--) begin
      hold_c[i] = stall[i] | hold_c[i+1];
    end
  end

  // Per-stage next state: flush beats hold; a frozen predecessor feeds a bubble.
  // pc/data are left untouched on flush and bubbles so they do not toggle.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    data_d  = data_q;

    if (flush[0]) begin
      valid_d[0] = 1'b0;
    end else if (!hold_c[0]) begin
      valid_d[0] = in_valid;
      pc_d[0]    = in_pc;
      data_d[0]  = in_data;
    end

    for (int i = 1; i < int'(STAGES); i++) begin
      if (flush[i]) begin
        valid_d[i] = 1'b0;
      end else if (!hold_c[i]) begin
        if (hold_c[i-1]) begin
          valid_d[i] = 1'b0;
        end else begin
          valid_d[i] = valid_q[i-1];
          pc_d[i]    = pc_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end
    end
  end

  // Stage registers, synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      pc_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
    end
  end

  assign in_ready    = ~hold_c[0];
  assign out_valid   = valid_q[LAST];
  assign out_pc      = pc_q[LAST];
  assign out_data    = data_q[LAST];
  assign stage_valid = valid_q;
  assign stage_pc    = pc_q;

`ifdef PIPE_RETIRE_CNT_EN
  logic             retire_c;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  // A valid last stage that is neither frozen nor killed retires this edge
  always_comb begin
    retire_c     = valid_q[LAST] & ~stall[LAST] & ~flush[LAST];
    retire_cnt_d = retire_cnt_q + CNT_W'(retire_c);
  end

  // Retire counter, wraps naturally at 2^CNT_W
  always_ff @(posedge CLK) begin
    if (RST) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios with hand-derived
// expectations plus a randomized run against a stage-array reference model.
module tb_pipe_stage_chain;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned STAGES = 4;
  localparam int unsigned CNT_W  = 4;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic                   in_valid;
  logic [PC_W-1:0]        in_pc;
  logic [WIDTH-1:0]       in_data;
  logic [STAGES-1:0]      stall;
  logic [STAGES-1:0]      flush;
  logic                   in_ready;
  logic                   out_valid;
  logic [PC_W-1:0]        out_pc;
  logic [WIDTH-1:0]       out_data;
  logic [STAGES-1:0]      stage_valid;
  logic [STAGES*PC_W-1:0] stage_pc;
`ifdef PIPE_RETIRE_CNT_EN
  logic [CNT_W-1:0]       retire_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents of each stage plus the retired count
  bit               m_v  [STAGES];
  logic [PC_W-1:0]  m_pc [STAGES];
  logic [WIDTH-1:0] m_d  [STAGES];
  int unsigned      m_cnt;

  always #5 CLK = ~CLK;

  pipe_stage_chain #(
    .WIDTH(WIDTH), .PC_W(PC_W), .STAGES(STAGES), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data),
    .stall(stall), .flush(flush),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_data(out_data),
    .stage_valid(stage_valid),
`ifdef PIPE_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .stage_pc(stage_pc)
  );

  // Advance one clock edge, updating the model from the inputs held across it
  task automatic step();
    bit               nv [STAGES];
    logic [PC_W-1:0]  npc[STAGES];
    logic [WIDTH-1:0] nd [STAGES];
    bit               hold[STAGES];
    for (int i = 0; i < int'(STAGES); i++) begin
      nv[i] = m_v[i]; npc[i] = m_pc[i]; nd[i] = m_d[i];
      hold[i] = ((stall >> i) != 0);
    end
    if (RST) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        nv[i] = 0; npc[i] = '0; nd[i] = '0;
      end
      m_cnt = 0;
    end else begin
      if (m_v[STAGES-1] && !stall[STAGES-1] && !flush[STAGES-1])
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      for (int i = 0; i < int'(STAGES); i++) begin
        if (flush[i]) nv[i] = 0;
        else if (hold[i]) ;
        else if (i == 0) begin nv[0] = in_valid; npc[0] = in_pc; nd[0] = in_data; end
        else if (hold[i-1]) nv[i] = 0;
        else begin nv[i] = m_v[i-1]; npc[i] = m_pc[i-1]; nd[i] = m_d[i-1]; end
      end
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < int'(STAGES); i++) begin
      m_v[i] = nv[i]; m_pc[i] = npc[i]; m_d[i] = nd[i];
    end
  endtask

  // Reset, then load four instructions at base, base+4, base+8, base+12
  task automatic fill_pipe(input logic [PC_W-1:0] base);
    RST = 1'b1; stall = '0; flush = '0; in_valid = 1'b0;
    step();
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = base + PC_W'(4 * k); in_data = $urandom;
      step();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; stall = '0; flush = '0; in_valid = 1'b0; in_pc = '0; in_data = '0;
    step(); step();
    RST = 1'b0;
    #1;
    n_tests++; if (stage_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", stage_valid); end
    n_tests++; if (stage_pc !== '0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", stage_pc); end
    n_tests++; if (out_valid !== 1'b0 || out_pc !== '0 || out_data !== '0) begin n_fail++; $display("FAIL reset_out: got v=%b pc=%h d=%h expected all 0", out_valid, out_pc, out_data); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
`ifdef PIPE_RETIRE_CNT_EN
    n_tests++; if (retire_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", retire_cnt); end
`endif
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] sd[16];
    RST = 1'b1; stall = '0; flush = '0; in_valid = 1'b0;
    step();
    RST = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      in_valid = 1'b1; in_pc = PC_W'((k - 1) * 4); sd[k-1] = $urandom; in_data = sd[k-1];
      step();
      if (k < 4) begin
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_fill k=%0d: got out_valid=%b expected 0", k, out_valid); end
      end else begin
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== PC_W'((k - 4) * 4) || out_data !== sd[k-4]) begin
          n_fail++;
          $display("FAIL stream_out k=%0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", k, out_valid, out_pc, out_data, (k - 4) * 4, sd[k-4]);
        end
      end
`ifdef PIPE_RETIRE_CNT_EN
      n_tests++; if (retire_cnt !== CNT_W'(k > 4 ? k - 4 : 0)) begin n_fail++; $display("FAIL stream_cnt k=%0d: got %0d expected %0d", k, retire_cnt, k > 4 ? k - 4 : 0); end
`endif
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    fill_pipe(32'h04);
    n_tests++; if (stage_pc !== {32'h04, 32'h08, 32'h0C, 32'h10}) begin n_fail++; $display("FAIL stall_setup: got %h", stage_pc); end
    in_pc = 32'h14; in_data = $urandom; stall = 4'b0010;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b expected 0", in_ready); end
    step();
    n_tests++; if (stage_valid !== 4'b1011 || stage_pc !== {32'h08, 32'h08, 32'h0C, 32'h10}) begin n_fail++; $display("FAIL stall_edge1: got v=%b pc=%h", stage_valid, stage_pc); end
    step();
    n_tests++; if (stage_valid !== 4'b0011 || stage_pc !== {32'h08, 32'h08, 32'h0C, 32'h10}) begin n_fail++; $display("FAIL stall_edge2: got v=%b pc=%h", stage_valid, stage_pc); end
    stall = '0;
    step();
    n_tests++; if (stage_valid !== 4'b0111 || stage_pc !== {32'h08, 32'h0C, 32'h10, 32'h14}) begin n_fail++; $display("FAIL stall_release: got v=%b pc=%h", stage_valid, stage_pc); end
    in_pc = 32'h18;
    step();
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h0C) begin n_fail++; $display("FAIL stall_resume0: got v=%b pc=%h expected 1 0c", out_valid, out_pc); end
    in_pc = 32'h1C;
    step();
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h10) begin n_fail++; $display("FAIL stall_resume1: got v=%b pc=%h expected 1 10", out_valid, out_pc); end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    int seen;
    fill_pipe(32'h100);
    in_pc = 32'h110; flush = 4'b0011;
    step();
    flush = '0; in_valid = 1'b0;
    n_tests++; if (stage_valid !== 4'b1100 || stage_pc !== {32'h104, 32'h108, 32'h108, 32'h10C}) begin n_fail++; $display("FAIL flush_edge: got v=%b pc=%h", stage_valid, stage_pc); end
    step();
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h108) begin n_fail++; $display("FAIL flush_adv: got v=%b pc=%h expected 1 108", out_valid, out_pc); end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      seen += int'(out_valid);
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL flush_drain: got %0d valid outputs expected 0", seen); end
`ifdef PIPE_RETIRE_CNT_EN
    n_tests++; if (retire_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL flush_cnt: got %0d expected 3", retire_cnt); end
`endif
  endtask

  task automatic test_flush_stall();
    fill_pipe(32'h200);
    in_pc = 32'h210; in_data = $urandom; stall = 4'b0100; flush = 4'b0100;
    step();
    n_tests++; if (stage_valid !== 4'b0011 || stage_pc !== {32'h200, 32'h204, 32'h208, 32'h20C}) begin n_fail++; $display("FAIL fs_edge: got v=%b pc=%h", stage_valid, stage_pc); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fs_ready: got %b expected 0", in_ready); end
`ifdef PIPE_RETIRE_CNT_EN
    n_tests++; if (retire_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL fs_cnt: got %0d expected 1", retire_cnt); end
`endif
    stall = '0; flush = '0;
    step();
    n_tests++; if (stage_valid !== 4'b0111 || stage_pc[PC_W-1:0] !== 32'h210) begin n_fail++; $display("FAIL fs_release: got v=%b pc0=%h", stage_valid, stage_pc[PC_W-1:0]); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    fill_pipe(32'h300);
    in_pc = 32'h310; stall = 4'b1000; RST = 1'b1;
    step();
    RST = 1'b0;
    n_tests++; if (stage_valid !== '0 || stage_pc !== '0 || out_pc !== '0 || out_data !== '0) begin n_fail++; $display("FAIL rstmid_state: got v=%b pc=%h out_d=%h expected 0", stage_valid, stage_pc, out_data); end
`ifdef PIPE_RETIRE_CNT_EN
    n_tests++; if (retire_cnt !== '0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", retire_cnt); end
`endif
    stall = '0; in_valid = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
  endtask

`ifdef PIPE_RETIRE_CNT_EN
  task automatic test_wrap();
    RST = 1'b1; stall = '0; flush = '0; in_valid = 1'b0;
    step();
    RST = 1'b0;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1; in_pc = PC_W'(k * 4); in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    n_tests++; if (retire_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL wrap_cnt: got %0d expected 1", retire_cnt); end
  endtask
`endif

  task automatic test_random();
    bit was_ready;
    RST = 1'b1; stall = '0; flush = '0; in_valid = 1'b0;
    step();
    RST = 1'b0;
    was_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (was_ready) begin
        in_valid = ($urandom_range(3, 0) != 0);
        in_pc    = $urandom;
        in_data  = $urandom;
      end
      for (int i = 0; i < int'(STAGES); i++) begin
        stall[i] = ($urandom_range(7, 0) == 0);
        flush[i] = ($urandom_range(15, 0) == 0);
      end
      RST = ($urandom_range(63, 0) == 0);
      #1;
      n_tests++; if (in_ready !== (stall == '0)) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, in_ready, stall == '0); end
      was_ready = (stall == '0);
      step();
      for (int i = 0; i < int'(STAGES); i++) begin
        n_tests++;
        if (stage_valid[i] !== m_v[i] || stage_pc[i*PC_W +: PC_W] !== m_pc[i]) begin
          n_fail++;
          $display("FAIL rnd_stage c=%0d s=%0d: got v=%b pc=%h expected v=%b pc=%h", c, i, stage_valid[i], stage_pc[i*PC_W +: PC_W], m_v[i], m_pc[i]);
        end
      end
      n_tests++; if (out_data !== m_d[STAGES-1]) begin n_fail++; $display("FAIL rnd_data c=%0d: got %h expected %h", c, out_data, m_d[STAGES-1]); end
`ifdef PIPE_RETIRE_CNT_EN
      n_tests++; if (retire_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c=%0d: got %0d expected %0d", c, retire_cnt, m_cnt); end
`endif
    end
    RST = 1'b0; stall = '0; flush = '0; in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_pc = '0; in_data = '0; stall = '0; flush = '0;
    m_cnt = 0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_flush_stall();
    test_reset_mid();
`ifdef PIPE_RETIRE_CNT_EN
    test_wrap();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
